// File: rtl/mips_div_pkg.sv
// Shared definitions for the MIPS iterative divider: default width and FSM state codes.
package mips_div_pkg;

  localparam int DIV_WIDTH_DEFAULT = 32;

  typedef logic [1:0] div_state_e;
  localparam div_state_e IDLE   = 2'd0;
  localparam div_state_e DIVIDE = 2'd1;
  localparam div_state_e FIXUP  = 2'd2;

endpackage

// File: rtl/div_sign_adjust.sv
// Conditional two's-complement negate; yields |value| when negate = sign bit in signed mode.
module div_sign_adjust
  import mips_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] result
);

  assign result = negate ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/mips_div_unit.sv
// Radix-2 restoring divider for MIPS DIV/DIVU: quotient -> LO, remainder -> HI.
// Optional early-exit when |dividend| < |divisor|, enabled by defining MIPS_DIV_FASTPATH_EN.
module mips_div_unit
  import mips_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic             abort,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  div_state_e       state;
  logic [CNT_W-1:0] counter;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic             sign_q;
  logic             sign_r;
  logic             dbz_q;

  logic [WIDTH-1:0] abs_dvd;
  logic [WIDTH-1:0] abs_dvs;
  logic [WIDTH-1:0] fix_quo;
  logic [WIDTH-1:0] fix_rem;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             fast_ok;

  div_sign_adjust #(.WIDTH(WIDTH)) u_abs_dvd (
    .value  (dividend),
    .negate (is_signed & dividend[WIDTH-1]),
    .result (abs_dvd)
  );

  div_sign_adjust #(.WIDTH(WIDTH)) u_abs_dvs (
    .value  (divisor),
    .negate (is_signed & divisor[WIDTH-1]),
    .result (abs_dvs)
  );

  div_sign_adjust #(.WIDTH(WIDTH)) u_fix_quo (
    .value  (quo_q),
    .negate (sign_q),
    .result (fix_quo)
  );

  div_sign_adjust #(.WIDTH(WIDTH)) u_fix_rem (
    .value  (rem_q),
    .negate (sign_r),
    .result (fix_rem)
  );

  // Magnitudes are unsigned WIDTH bits, so |MIN| fits; the trial runs in WIDTH+1 bits.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs_q};

`ifdef MIPS_DIV_FASTPATH_EN
  assign fast_ok = (divisor != '0) && (abs_dvd < abs_dvs);
`else
  assign fast_ok = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      counter     <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      dbz_q       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            dvs_q  <= abs_dvs;
            sign_q <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            sign_r <= is_signed & dividend[WIDTH-1];
            dbz_q  <= (divisor == '0);
            busy   <= 1'b1;
            if (fast_ok) begin
              quo_q   <= '0;
              rem_q   <= abs_dvd;
              counter <= '0;
              state   <= FIXUP;
            end else begin
              quo_q   <= abs_dvd;
              rem_q   <= '0;
              counter <= CNT_W'(WIDTH);
              state   <= DIVIDE;
            end
          end
        end
        DIVIDE: begin
          if (abort) begin
            state   <= IDLE;
            busy    <= 1'b0;
            counter <= '0;
          end else begin
            rem_q   <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
            quo_q   <= {quo_q[WIDTH-2:0], ~trial[WIDTH]};
            counter <= counter - CNT_W'(1);
            if (counter == CNT_W'(1)) begin
              state <= FIXUP;
            end
          end
        end
        FIXUP: begin
          state <= IDLE;
          busy  <= 1'b0;
          // A zero divisor leaves rem = |dividend|, so the sign fixup restores the dividend.
          if (!abort) begin
            done        <= 1'b1;
            quotient    <= dbz_q ? '1 : fix_quo;
            remainder   <= fix_rem;
            div_by_zero <= dbz_q;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_div_unit.sv
// Self-checking bench for mips_div_unit: directed literal cases plus randomized ops vs. a latency/arithmetic model.
module tb_mips_div_unit;

  localparam int WIDTH    = 32;
  localparam int LAT_FULL = WIDTH + 1;
  localparam logic [31:0] MIN_VAL = 32'h8000_0000;
`ifdef MIPS_DIV_FASTPATH_EN
  localparam int LAT_FAST = 1;
`else
  localparam int LAT_FAST = LAT_FULL;
`endif

  logic        clk       = 1'b0;
  logic        reset_n   = 1'b0;
  logic        start     = 1'b0;
  logic        is_signed = 1'b0;
  logic        abort     = 1'b0;
  logic [31:0] dividend  = '0;
  logic [31:0] divisor   = '0;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int total_checks  = 0;
  int passed_checks = 0;

  always #5 clk = ~clk;

  mips_div_unit #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .is_signed   (is_signed),
    .abort       (abort),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    total_checks++;
    if (got === exp) passed_checks++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  // Reference arithmetic straight from the instruction semantics.
  function automatic longint magnitude(input logic s, input logic [31:0] v);
    longint x;
    if (s) x = $signed(v);
    else   x = {32'd0, v};
    return (x < 0) ? -x : x;
  endfunction

  function automatic void ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r, output logic z);
    longint sa, sb;
    if (b == 32'd0) begin
      q = '1; r = a; z = 1'b1;
    end else begin
      z = 1'b0;
      if (s) begin
        sa = $signed(a);
        sb = $signed(b);
        q  = 32'(sa / sb);
        r  = 32'(sa % sb);
      end else begin
        q = a / b;
        r = a % b;
      end
    end
  endfunction

  function automatic int expected_latency(input logic s, input logic [31:0] a, input logic [31:0] b);
    if (b != 32'd0 && magnitude(s, a) < magnitude(s, b)) return LAT_FAST;
    return LAT_FULL;
  endfunction

  // Transaction-level model: an accepted op completes a fixed number of edges later unless aborted.
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  int          m_left = 0;
  logic [31:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
  logic        m_z = 1'b0, p_z = 1'b0;

  always @(posedge clk or negedge reset_n) begin : model
    logic [31:0] q_tmp, r_tmp;
    logic        z_tmp;
    if (!reset_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_left <= 0;
      m_q <= '0; m_r <= '0; m_z <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (abort) m_busy <= 1'b0;
        else if (m_left == 1) begin
          m_busy <= 1'b0; m_done <= 1'b1;
          m_q <= p_q; m_r <= p_r; m_z <= p_z;
        end else m_left <= m_left - 1;
      end else if (start && !abort) begin
        ref_div(is_signed, dividend, divisor, q_tmp, r_tmp, z_tmp);
        p_q <= q_tmp; p_r <= r_tmp; p_z <= z_tmp;
        m_busy <= 1'b1;
        m_left <= expected_latency(is_signed, dividend, divisor);
      end
    end
  end

  always @(negedge clk) begin
    checkOutput("cyc_busy", {63'd0, busy}, {63'd0, m_busy});
    checkOutput("cyc_done", {63'd0, done}, {63'd0, m_done});
    checkOutput("cyc_quotient", {32'd0, quotient}, {32'd0, m_q});
    checkOutput("cyc_remainder", {32'd0, remainder}, {32'd0, m_r});
    checkOutput("cyc_div_by_zero", {63'd0, div_by_zero}, {63'd0, m_z});
  end

  // Issues one op and waits (bounded) for done; edges counts rising edges after the sampling edge.
  task automatic applyStimulus(input logic s, input logic [31:0] a, input logic [31:0] b,
                               input bit immediate, output int edges, output bit seen);
    if (!immediate) @(negedge clk);
    start = 1'b1; is_signed = s; dividend = a; divisor = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 100) begin
      if (done) seen = 1'b1;
      else begin
        @(negedge clk);
        edges++;
      end
    end
  endtask

  task automatic runOp(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er, input logic ez, input int elat,
                       input bit immediate);
    int edges;
    bit seen;
    applyStimulus(s, a, b, immediate, edges, seen);
    checkOutput({tag, "_done_seen"}, {63'd0, seen}, 64'd1);
    checkOutput({tag, "_latency"}, 64'(edges), 64'(elat));
    checkOutput({tag, "_quotient"}, {32'd0, quotient}, {32'd0, eq});
    checkOutput({tag, "_remainder"}, {32'd0, remainder}, {32'd0, er});
    checkOutput({tag, "_div_by_zero"}, {63'd0, div_by_zero}, {63'd0, ez});
  endtask

  initial begin
    int done_count;
    logic [31:0] a, b, eq, er;
    logic s, ez;

    repeat (2) @(negedge clk);
    checkOutput("reset_busy", {63'd0, busy}, 64'd0);
    checkOutput("reset_done", {63'd0, done}, 64'd0);
    checkOutput("reset_quotient", {32'd0, quotient}, 64'd0);
    checkOutput("reset_remainder", {32'd0, remainder}, 64'd0);
    checkOutput("reset_div_by_zero", {63'd0, div_by_zero}, 64'd0);
    reset_n = 1'b1;

    $display("[TB] directed cases");
    runOp("u100_7", 1'b0, 32'd100, 32'd7, 32'h0000_000E, 32'h2, 1'b0, LAT_FULL, 1'b0);
    runOp("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, LAT_FULL, 1'b0);
    runOp("s_min_m1", 1'b1, MIN_VAL, 32'hFFFF_FFFF, MIN_VAL, 32'h0, 1'b0, LAT_FULL, 1'b1);
    runOp("dbz_u", 1'b0, 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 1'b1, LAT_FULL, 1'b0);
    runOp("dbz_s", 1'b1, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FF00, 1'b1, LAT_FULL, 1'b0);
    runOp("u3_10", 1'b0, 32'd3, 32'd10, 32'h0, 32'h3, 1'b0, LAT_FAST, 1'b0);
    runOp("s_m3_10", 1'b1, 32'hFFFF_FFFD, 32'd10, 32'h0, 32'hFFFF_FFFD, 1'b0, LAT_FAST, 1'b1);

    $display("[TB] abort mid-divide");
    runOp("pre_abort", 1'b0, 32'd100, 32'd7, 32'h0000_000E, 32'h2, 1'b0, LAT_FULL, 1'b0);
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; dividend = 32'd999; divisor = 32'd5;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1; dividend = 32'd50; divisor = 32'd3;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    checkOutput("abort_busy", {63'd0, busy}, 64'd0);
    checkOutput("abort_done", {63'd0, done}, 64'd0);
    checkOutput("abort_quotient", {32'd0, quotient}, 64'hE);
    checkOutput("abort_remainder", {32'd0, remainder}, 64'h2);
    done_count = 0;
    repeat (40) begin @(negedge clk); if (done) done_count++; end
    checkOutput("abort_no_done", 64'(done_count), 64'd0);

    $display("[TB] start while busy");
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; dividend = 32'd1000; divisor = 32'd3;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; dividend = 32'd50; divisor = 32'd7;
    @(negedge clk); start = 1'b0;
    done_count = 0;
    repeat (60) begin @(negedge clk); if (done) done_count++; end
    checkOutput("busy_start_single_done", 64'(done_count), 64'd1);
    checkOutput("busy_start_quotient", {32'd0, quotient}, 64'd333);
    checkOutput("busy_start_remainder", {32'd0, remainder}, 64'd1);

    $display("[TB] start with abort in idle");
    @(negedge clk);
    start = 1'b1; abort = 1'b1; dividend = 32'd9; divisor = 32'd2;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    checkOutput("idle_abort_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    checkOutput("idle_abort_busy2", {63'd0, busy}, 64'd0);

    $display("[TB] async reset mid-divide");
    runOp("pre_reset", 1'b0, 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 1'b1, LAT_FULL, 1'b0);
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (6) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("rst_busy", {63'd0, busy}, 64'd0);
    checkOutput("rst_done", {63'd0, done}, 64'd0);
    checkOutput("rst_quotient", {32'd0, quotient}, 64'd0);
    checkOutput("rst_remainder", {32'd0, remainder}, 64'd0);
    checkOutput("rst_div_by_zero", {63'd0, div_by_zero}, 64'd0);
    @(negedge clk); reset_n = 1'b1;
    runOp("post_reset", 1'b0, 32'd100, 32'd7, 32'h0000_000E, 32'h2, 1'b0, LAT_FULL, 1'b0);

    $display("[TB] randomized ops");
    for (int i = 0; i < 150; i++) begin
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: begin a = $urandom; b = $urandom; end
        1: begin a = $urandom_range(0, 255); b = $urandom_range(1, 20); end
        2: begin a = $urandom; b = 32'd0; end
        3: begin a = MIN_VAL; b = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : $urandom; end
        4: begin
          a = $urandom; b = $urandom_range(1, 1000);
          if ($urandom_range(0, 1) == 1) b = ~b + 32'd1;
        end
        default: begin
          a = $urandom_range(0, 50); b = $urandom;
          if ($urandom_range(0, 1) == 1) a = ~a + 32'd1;
        end
      endcase
      ref_div(s, a, b, eq, er, ez);
      runOp("rand", s, a, b, eq, er, ez, expected_latency(s, a, b), 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
